// File: rtl/sp_ram.sv
// sp_ram: single-port synchronous RAM with a registered read port.
// One shared address serves both read and write.
// A read during a write returns the word being written (write-through).
// Optional build macro SP_RAM_OUTREG_EN adds a second output register,
// which raises the read latency from 1 to 2 clocks.
// The reset is synchronous and active-low. It clears only the output
// register(s) and never the storage array.

module sp_ram #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Storage array: no reset so it maps onto block RAM; writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (rst_n && wren) begin
            mem[address] <= data;
        end
    end

    // Read register: write-through on a write, otherwise the stored word; cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (wren) begin
            rd_q <= data;
        end else begin
            rd_q <= mem[address];
        end
    end

`ifdef SP_RAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] out_q;

    // Second output stage: delays the read data by one more clock; cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= rd_q;
        end
    end

    assign q = out_q;
`else
    assign q = rd_q;
`endif

endmodule

// File: tb/tb_sp_ram.sv
// tb_sp_ram: scoreboard testbench for sp_ram.
// The stimulus process queues the expected q value for each clock edge.
// A separate monitor process pops and compares one entry after every edge.

module tb_sp_ram;

    localparam int DW    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef SP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wren;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic [DW-1:0] q;

    typedef struct {
        bit            care;
        logic [DW-1:0] val;
        int            tag;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_mem[DEPTH];
    bit            written[DEPTH];
    bit            prev_care = 1'b0;
    logic [DW-1:0] prev_val  = '0;
    int            total  = 0;
    int            bad    = 0;
    int            issued = 0;

    sp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wren    (wren),
        .address (address),
        .data    (data),
        .q       (q)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Drive one clock's inputs and queue the q value expected after the next edge
    task automatic applyStimulus(input logic r, input logic w,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t          e;
        bit            rc;
        logic [DW-1:0] rv;
        @(negedge clk);
        rst_n   = r;
        wren    = w;
        address = a;
        data    = d;
        // Read result of this edge in an ideal zero-extra-latency memory
        if (!r) begin
            rc = 1'b1; rv = '0;
        end else if (w) begin
            rc = 1'b1; rv = d;
        end else begin
            rc = written[a]; rv = model_mem[a];
        end
        if (r && w) begin
            model_mem[a] = d;
            written[a]   = 1'b1;
        end
        // Visible result depends on the pipeline depth; reset forces zero
        if (!r) begin
            e.care = 1'b1; e.val = '0;
        end else if (LAT == 1) begin
            e.care = rc; e.val = rv;
        end else begin
            e.care = prev_care; e.val = prev_val;
        end
        prev_care = rc;
        prev_val  = rv;
        e.tag  = issued;
        e.addr = a;
        issued++;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.care) begin
            total++;
            if (q !== e.val) begin
                bad++;
                $display("[TB] FAIL q_check #%0d addr=%h: got q=%h want %h", e.tag, e.addr, q, e.val);
            end
        end
    endtask

    // Monitor: one scoreboard entry per clock edge, sampled 1 time unit after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    // Stimulus sequence
    initial begin
        int waited;
        rst_n   = 1'b0;
        wren    = 1'b0;
        address = '0;
        data    = '0;

        // Reset state
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);

        // Fill all words with ~address (write-through shows each value)
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b1, AW'(i), ~DW'(i));
        end

        // Readback with address wrap F -> 0
        for (int i = 0; i < DEPTH + 4; i++) begin
            applyStimulus(1'b1, 1'b0, AW'(i), 4'h0);
        end

        // Read-during-write at address 3
        applyStimulus(1'b1, 1'b1, 4'h3, 4'h7);
        applyStimulus(1'b1, 1'b1, 4'h3, 4'hC);
        applyStimulus(1'b1, 1'b0, 4'h3, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h3, 4'h0);

        // Reset with a write request that must be suppressed
        applyStimulus(1'b0, 1'b1, 4'h2, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'h2, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h2, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h2, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h2, 4'h0);

        // Unknown write enable counts as no write
        applyStimulus(1'b1, 1'bx, 4'h5, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h5, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h5, 4'h0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
                          AW'($urandom), DW'($urandom));
        end
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h1, 4'h0);

        // Drain the scoreboard within a bounded number of cycles
        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
